// File: rtl/l0_instr_cache_pkg.sv
// Shared definitions for the L0 instruction cache frontend.
package l0_instr_cache_pkg;

  localparam int unsigned INSTR_BITS       = 32;
  localparam int unsigned WORD_OFFSET_BITS = 2;
  localparam int unsigned DEFAULT_LINE_BYTES = 64;
  localparam int unsigned DEFAULT_LINE_OFFSET_BITS = $clog2(DEFAULT_LINE_BYTES);

  // The four controller states of the fetch path.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  // One valid/ready pair; a transfer happens when both are high on an edge.
  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

  // Number of address bits that select a byte inside a line of the given size.
  function automatic int unsigned line_offset_bits(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/l0_instr_cache_line_array.sv
// Fully associative tag/valid/data store with FIFO replacement.
module l0_line_array
  import l0_instr_cache_pkg::*;
#(
  parameter int N_LINES    = 4,
  parameter int B          = 64,
  parameter int PADDR_BITS = 64
) (
  input  logic                                        clk_in,
  input  logic                                        rst_N_in,
  input  logic                                        flush_in,
  input  logic [PADDR_BITS-line_offset_bits(B)-1:0]   lookup_tag_in,
  output logic                                        hit_out,
  output logic [8*B-1:0]                              hit_line_out,
  input  logic                                        fill_en_in,
  input  logic [PADDR_BITS-line_offset_bits(B)-1:0]   fill_tag_in,
  input  logic [8*B-1:0]                              fill_data_in
);

  localparam int OFF   = line_offset_bits(B);
  localparam int TAG_W = PADDR_BITS - OFF;
  localparam int PTR_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;

  logic [N_LINES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [N_LINES];
  logic [8*B-1:0]     data_q [N_LINES];
  logic [PTR_W-1:0]   ptr_q;

  logic [PTR_W-1:0]   hit_idx;
  logic               fill_same;
  logic [PTR_W-1:0]   fill_same_idx;
  logic [PTR_W-1:0]   fill_idx;

  // Search all entries for the lookup tag and for an existing copy of the fill tag.
  always_comb begin
    hit_out       = 1'b0;
    hit_idx       = '0;
    fill_same     = 1'b0;
    fill_same_idx = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_tag_in) begin
        hit_out = 1'b1;
        hit_idx = PTR_W'(i);
      end
      if (valid_q[i] && tag_q[i] == fill_tag_in) begin
        fill_same     = 1'b1;
        fill_same_idx = PTR_W'(i);
      end
    end
  end

  assign hit_line_out = data_q[hit_idx];
  assign fill_idx     = fill_same ? fill_same_idx : ptr_q;

  // Valid bits and FIFO pointer; flush clears every entry, reuse of a same-tag slot keeps the pointer.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (flush_in) begin
      valid_q <= '0;
    end else if (fill_en_in) begin
      valid_q[fill_idx] <= 1'b1;
      if (!fill_same) begin
        ptr_q <= (ptr_q == PTR_W'(N_LINES - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    if (fill_en_in && !flush_in) begin
      tag_q[fill_idx]  <= fill_tag_in;
      data_q[fill_idx] <= fill_data_in;
    end
  end

endmodule

// File: rtl/l0_instr_cache.sv
// L0 instruction cache: 1-cycle hit path, single outstanding miss to L1i.
module l0_instr_cache
  import l0_instr_cache_pkg::*;
#(
  parameter int N_LINES    = 4,
  parameter int B          = 64,
  parameter int PADDR_BITS = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  flush_in,
  input  logic                  fetch_valid_in,
  input  logic [63:0]           fetch_pc_in,
  output logic                  fetch_ready_out,
  output logic                  instr_valid_out,
  input  logic                  instr_ready_in,
  output logic [31:0]           instr_out,
  output logic [63:0]           instr_pc_out,
  output logic                  l1_valid_out,
  input  logic                  l1_ready_in,
  output logic [PADDR_BITS-1:0] l1_addr_out,
  input  logic                  l1_valid_in,
  output logic                  l1_ready_out,
  input  logic [PADDR_BITS-1:0] l1_addr_in,
  input  logic [8*B-1:0]        l1_value_in
);

  localparam int OFF    = line_offset_bits(B);
  localparam int TAG_W  = PADDR_BITS - OFF;
  localparam int WIDX_W = OFF - WORD_OFFSET_BITS;

  state_t              state_q, state_d;
  logic [63:0]         pc_q;
  logic [31:0]         instr_q;
  logic                drop_fill_q;

  handshake_t          fetch_hs, l1_req_hs, l1_ret_hs;
  logic                arr_hit;
  logic [8*B-1:0]      arr_line;
  logic                lookup_hit;
  logic                ret_match;
  logic                fill_fire;
  logic                fill_en;
  logic [TAG_W-1:0]    pend_tag;
  logic [WIDX_W-1:0]   fetch_widx, pend_widx;
  logic [31:0]         hit_word, fill_word;
  logic                unused_bits;

  assign pend_tag   = pc_q[PADDR_BITS-1:OFF];
  assign fetch_widx = fetch_pc_in[OFF-1:WORD_OFFSET_BITS];
  assign pend_widx  = pc_q[OFF-1:WORD_OFFSET_BITS];
  assign hit_word   = arr_line[{fetch_widx, 5'b0} +: INSTR_BITS];
  assign fill_word  = l1_value_in[{pend_widx, 5'b0} +: INSTR_BITS];
  assign unused_bits = ^l1_addr_in[OFF-1:0];

  assign fetch_hs.valid  = fetch_valid_in;
  assign fetch_hs.ready  = fetch_ready_out;
  assign l1_req_hs.valid = l1_valid_out;
  assign l1_req_hs.ready = l1_ready_in;
  assign l1_ret_hs.valid = l1_valid_in;
  assign l1_ret_hs.ready = l1_ready_out;

  // A flush in the lookup cycle wins, so the fetch goes out as a miss.
  assign lookup_hit = arr_hit && !flush_in;
  assign ret_match  = l1_ret_hs.valid && l1_ret_hs.ready && (l1_addr_in[PADDR_BITS-1:OFF] == pend_tag);
  assign fill_fire  = (state_q == MISS_WAIT) && ret_match;
  assign fill_en    = fill_fire && !drop_fill_q && !flush_in;

  l0_line_array #(
    .N_LINES    (N_LINES),
    .B          (B),
    .PADDR_BITS (PADDR_BITS)
  ) u_line_array (
    .clk_in        (clk_in),
    .rst_N_in      (rst_N_in),
    .flush_in      (flush_in),
    .lookup_tag_in (fetch_pc_in[PADDR_BITS-1:OFF]),
    .hit_out       (arr_hit),
    .hit_line_out  (arr_line),
    .fill_en_in    (fill_en),
    .fill_tag_in   (pend_tag),
    .fill_data_in  (l1_value_in)
  );

  // Next-state and handshake outputs; ready is held off while reset is asserted.
  always_comb begin
    state_d         = state_q;
    fetch_ready_out = 1'b0;
    instr_valid_out = 1'b0;
    l1_valid_out    = 1'b0;
    l1_ready_out    = 1'b0;
    l1_addr_out     = '0;
    case (state_q)
      IDLE: begin
        fetch_ready_out = rst_N_in;
        if (fetch_valid_in && rst_N_in) begin
          state_d = lookup_hit ? RESP : MISS_REQ;
        end
      end
      MISS_REQ: begin
        l1_valid_out = 1'b1;
        l1_addr_out  = {pend_tag, {OFF{1'b0}}};
        if (l1_ready_in) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        l1_ready_out = 1'b1;
        if (ret_match) begin
          state_d = RESP;
        end
      end
      RESP: begin
        instr_valid_out = 1'b1;
        if (instr_ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured PC and response word; a flush while a miss is open cancels its install.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      drop_fill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_hs.valid && fetch_hs.ready) begin
        pc_q        <= fetch_pc_in;
        instr_q     <= hit_word;
        drop_fill_q <= 1'b0;
      end
      if (flush_in && (state_q == MISS_REQ || state_q == MISS_WAIT)) begin
        drop_fill_q <= 1'b1;
      end
      if (fill_fire) begin
        instr_q <= fill_word;
      end
    end
  end

  assign instr_out    = instr_q;
  assign instr_pc_out = pc_q;

endmodule

// File: doc/l0_instr_cache.md
L0_INSTR_CACHE -- requirements
Module: l0_instr_cache

Interface
REQ-001 SHALL have parameter N_LINES, default 4: number of fully-associative line entries.
REQ-002 SHALL have parameter B, default 64: line size in bytes (8*B-bit line).
REQ-003 SHALL have parameter PADDR_BITS, default 64: physical address width.
REQ-004 clk_in  input  1  the only clock; all state updates on its rising edge.
REQ-005 rst_N_in  input  1  reset, synchronous and active-low.
REQ-006 flush_in  input  1  invalidates all entries.
REQ-007 fetch_valid_in  input  1  fetch request valid.
REQ-008 fetch_pc_in  input  64  fetch PC, 4-byte aligned.
REQ-009 fetch_ready_out  output  1  fetch request accepted.
REQ-010 instr_valid_out  output  1  instruction response valid.
REQ-011 instr_ready_in  input  1  fetch unit consumes response.
REQ-012 instr_out  output  32  fetched instruction word.
REQ-013 instr_pc_out  output  64  PC of instr_out.
REQ-014 l1_valid_out / l1_ready_in  output / input  1 / 1  miss request handshake to L1i.
REQ-015 l1_addr_out  output  PADDR_BITS  line-aligned miss address.
REQ-016 l1_valid_in / l1_ready_out  input / output  1 / 1  line return handshake from L1i.
REQ-017 l1_addr_in, l1_value_in  input  PADDR_BITS, 8*B  returned line address and data.

Function
REQ-018 A transfer SHALL occur on a rising edge where valid and ready are both high; a valid SHALL stay high with stable payload until it transfers.
REQ-019 FSM states SHALL be IDLE, MISS_REQ, MISS_WAIT, RESP.
REQ-020 IDLE: fetch_ready_out=1; an accepted fetch captures the PC; on hit, go to RESP with instr_valid_out high in the next cycle (1-cycle hit latency); on miss, go to MISS_REQ.
REQ-021 Hit SHALL be a valid entry whose tag equals pc[PADDR_BITS-1:log2(B)]; instr_out SHALL be the 32-bit word at index pc[log2(B)-1:2], little-endian within the line.
REQ-022 MISS_REQ: l1_valid_out=1 and l1_addr_out = PC with the low log2(B) bits zeroed; on transfer, go to MISS_WAIT.
REQ-023 MISS_WAIT: l1_ready_out=1; accept l1_valid_in only when l1_addr_in line equals the pending line, and ignore non-matching returns; on accept, write the line into the FIFO-pointer entry, set it valid, advance the pointer modulo N_LINES, and go to RESP.
REQ-024 RESP: instr_valid_out=1 with the payload held; on instr_ready_in, go to IDLE; fetch_ready_out=0 in every state except IDLE.
REQ-025 flush_in SHALL clear all valid bits on the next edge. In IDLE it SHALL take priority over a same-cycle lookup, so that fetch is treated as a miss. During MISS_WAIT the returned line SHALL still be delivered to fetch but SHALL NOT be installed.
REQ-026 A fill SHALL overwrite a same-tag entry if one exists, never creating duplicate tags.

Reset
REQ-027 While rst_N_in=0 at a rising edge: state=IDLE, all valid bits 0, FIFO pointer 0, all outputs 0 (fetch_ready_out becomes 1 in the first IDLE cycle after reset); reset mid-miss SHALL abandon the request.

Structure
REQ-028 The state enum, the line/offset width constants and the handshake struct SHALL live in a shared frontend cache package.
REQ-029 The tag/valid/data array with a hit-index lookup SHALL be one sub-module, l0_line_array.

Verification
REQ-030 Cold fetch of pc 0x1004: l1_addr_out=0x1000; return line with word1=0xDEADBEEF -> instr_out=0xDEADBEEF, instr_pc_out=0x1004.
REQ-031 Refetch of pc 0x1008 after the 0x1000 fill -> no l1_valid_out, instr_valid_out one cycle after acceptance.
REQ-032 Fill 5 distinct lines 0x0,0x40,...,0x100 -> 0x0 evicted (miss again), 0x40 still hits.
REQ-033 l1_ready_in held low 10 cycles -> l1_valid_out and l1_addr_out stable throughout; instr_ready_in low -> response held.
REQ-034 Line return with l1_addr_in=0x2000 while 0x1000 is pending -> ignored; flush during MISS_WAIT -> response delivered, then refetch misses.
REQ-035 rst_N_in low in MISS_WAIT -> next cycle IDLE, all outputs 0, prior lines miss.
